controle_param: RTL and testbench

CONTROLE_PARAM -- requirements
Module: controle_param

---
 rtl/controle_param.sv | 156 +++++++++++++++
 tb/tb_controle_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_param.sv
// Multi-cycle control unit for a register/ALU/memory datapath (IDLE, T1..T4).
// Optional PUSH/POP support is enabled by defining CONTROLE_STACK_OPS_EN.
module controle_param #(
  parameter int REG_BITS = 3
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     run,
  input  logic [4+2*REG_BITS-1:0]  ir,
  input  logic                     nz,
  output logic [(2**REG_BITS)-1:0] r_in,
  output logic [(2**REG_BITS)-1:0] r_out,
  output logic                     a_in,
  output logic                     g_in,
  output logic                     g_out,
  output logic                     dinout,
  output logic                     addr_in,
  output logic                     dout_in,
  output logic                     wren,
  output logic                     memoria,
  output logic [2:0]               alu_op,
  output logic                     sp_inc,
  output logic                     sp_dec,
  output logic                     done,
  output logic                     err,
  output logic                     busy
);
  localparam int NREGS = 2**REG_BITS;
  localparam int IR_W  = 4 + 2*REG_BITS;

  localparam logic [3:0] OP_MV   = 4'b0000, OP_MVI  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB  = 4'b0011, OP_LD   = 4'b0100, OP_ST  = 4'b0101,
                         OP_MVNZ = 4'b0110, OP_SLT  = 4'b0111, OP_CMP = 4'b1000,
                         OP_PUSH = 4'b1001, OP_POP  = 4'b1010;

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [3:0]        opcode;
  logic [NREGS-1:0]  x_oh, y_oh;
  logic              is_alu;

  assign opcode = ir_q[IR_W-1 -: 4];
  assign x_oh   = NREGS'(1) << ir_q[2*REG_BITS-1 -: REG_BITS];
  assign y_oh   = NREGS'(1) << ir_q[REG_BITS-1:0];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_MVNZ) ||
                  (opcode == OP_SLT) || (opcode == OP_CMP);

`ifdef CONTROLE_STACK_OPS_EN
  localparam int SP = NREGS - 1;
  logic [NREGS-1:0] sp_oh;
  assign sp_oh = NREGS'(1) << SP;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    r_in = '0; r_out = '0; a_in = 1'b0; g_in = 1'b0; g_out = 1'b0;
    dinout = 1'b0; addr_in = 1'b0; dout_in = 1'b0; wren = 1'b0; memoria = 1'b0;
    alu_op = 3'b000; sp_inc = 1'b0; sp_dec = 1'b0; done = 1'b0; err = 1'b0;
    busy = (state_q != S_IDLE);
    state_d = state_q;
    ir_d    = ir_q;

    case (state_q)
      S_T1: begin
        if (is_alu) begin
          r_out = x_oh; a_in = 1'b1;
        end else begin
          case (opcode)
            OP_MV:  begin r_out = y_oh; r_in = x_oh; done = 1'b1; end
            OP_MVI: begin dinout = 1'b1; r_in = x_oh; done = 1'b1; end
            OP_LD, OP_ST: begin r_out = y_oh; addr_in = 1'b1; end
`ifdef CONTROLE_STACK_OPS_EN
            OP_PUSH: sp_dec = 1'b1;
            OP_POP:  begin r_out = sp_oh; addr_in = 1'b1; end
`endif
            default: begin err = 1'b1; done = 1'b1; end
          endcase
        end
      end
      S_T2: begin
        if (is_alu) begin
          r_out = y_oh; g_in = 1'b1;
          case (opcode)
            OP_SUB:  alu_op = 3'b001;
            OP_MVNZ: alu_op = 3'b010;
            OP_SLT:  alu_op = 3'b011;
            OP_CMP:  alu_op = 3'b100;
            default: alu_op = 3'b000;
          endcase
        end else begin
          case (opcode)
            OP_ST: begin r_out = x_oh; dout_in = 1'b1; end
`ifdef CONTROLE_STACK_OPS_EN
            OP_PUSH: begin r_out = sp_oh; addr_in = 1'b1; end
            OP_POP:  sp_inc = 1'b1;
`endif
            default: ;
          endcase
        end
      end
      S_T3: begin
        if (is_alu) begin
          // MVNZ commits the write-back only when G was nonzero
          g_out = 1'b1; done = 1'b1;
          r_in  = ((opcode != OP_MVNZ) || nz) ? x_oh : '0;
        end else begin
          case (opcode)
            OP_LD: begin memoria = 1'b1; r_in = x_oh; done = 1'b1; end
            OP_ST: begin wren = 1'b1; done = 1'b1; end
`ifdef CONTROLE_STACK_OPS_EN
            OP_PUSH: begin r_out = x_oh; dout_in = 1'b1; end
            OP_POP:  begin memoria = 1'b1; r_in = x_oh; done = 1'b1; end
`endif
            default: ;
          endcase
        end
      end
      S_T4: begin
`ifdef CONTROLE_STACK_OPS_EN
        if (opcode == OP_PUSH) begin
          wren = 1'b1; done = 1'b1;
        end
`endif
      end
      default: ;
    endcase

    // Idle and done cycles both accept a new instruction, giving back-to-back issue
    if ((state_q == S_IDLE) || done) begin
      if (run) begin
        state_d = S_T1;
        ir_d    = ir;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_T1:    state_d = S_T2;
        S_T2:    state_d = S_T3;
        S_T3:    state_d = S_T4;
        default: state_d = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_controle_param.sv
// Randomized scoreboard bench for controle_param: a per-instruction micro-step
// model feeds an expected-output queue that a negedge monitor drains.
module tb_controle_param;
  typedef struct packed {
    logic [7:0] r_in;
    logic [7:0] r_out;
    logic a_in, g_in, g_out, dinout, addr_in, dout_in, wren, memoria;
    logic [2:0] alu_op;
    logic sp_inc, sp_dec, done, err, busy;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    nz_gate;
    int    op;
    int    stp;
  } step_t;

`ifdef CONTROLE_STACK_OPS_EN
  localparam bit STACK = 1'b1;
`else
  localparam bit STACK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       run = 1'b0;
  logic [9:0] ir = '0;
  logic       nz = 1'b0;
  logic [7:0] r_in, r_out;
  logic a_in, g_in, g_out, dinout, addr_in, dout_in, wren, memoria;
  logic [2:0] alu_op;
  logic sp_inc, sp_dec, done, err, busy;

  logic       run2 = 1'b0;
  logic [7:0] ir2 = '0;
  logic [3:0] r_in2, r_out2;
  logic a_in2, g_in2, g_out2, dinout2, addr_in2, dout_in2, wren2, memoria2;
  logic [2:0] alu_op2;
  logic sp_inc2, sp_dec2, done2, err2, busy2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  controle_param #(.REG_BITS(3)) dut (
    .clock(clock), .resetn(resetn), .run(run), .ir(ir), .nz(nz),
    .r_in(r_in), .r_out(r_out), .a_in(a_in), .g_in(g_in), .g_out(g_out),
    .dinout(dinout), .addr_in(addr_in), .dout_in(dout_in), .wren(wren),
    .memoria(memoria), .alu_op(alu_op), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .done(done), .err(err), .busy(busy)
  );

  controle_param #(.REG_BITS(2)) dut2 (
    .clock(clock), .resetn(resetn), .run(run2), .ir(ir2), .nz(nz),
    .r_in(r_in2), .r_out(r_out2), .a_in(a_in2), .g_in(g_in2), .g_out(g_out2),
    .dinout(dinout2), .addr_in(addr_in2), .dout_in(dout_in2), .wren(wren2),
    .memoria(memoria2), .alu_op(alu_op2), .sp_inc(sp_inc2), .sp_dec(sp_dec2),
    .done(done2), .err(err2), .busy(busy2)
  );

  outs_t act;
  assign act = {r_in, r_out, a_in, g_in, g_out, dinout, addr_in, dout_in, wren,
                memoria, alu_op, sp_inc, sp_dec, done, err, busy};

  outs_t sbq[$];
  step_t pend[$];
  int    cyc = 0;

  function automatic outs_t blank();
    outs_t s = '0;
    s.busy = 1'b1;
    return s;
  endfunction

  function automatic void add(outs_t o, bit gate, int op);
    step_t s;
    s.o = o; s.nz_gate = gate; s.op = op; s.stp = pend.size() + 1;
    pend.push_back(s);
  endfunction

  // Expected micro-step list of one instruction, written straight from the ISA table
  function automatic void build(logic [9:0] irv);
    int op;
    logic [7:0] xo, yo;
    outs_t s;
    op = int'(irv[9:6]);
    xo = 8'(1) << irv[5:3];
    yo = 8'(1) << irv[2:0];
    pend.delete();
    if (op == 0) begin
      s = blank(); s.r_out = yo; s.r_in = xo; s.done = 1; add(s, 0, op);
    end else if (op == 1) begin
      s = blank(); s.dinout = 1; s.r_in = xo; s.done = 1; add(s, 0, op);
    end else if (op == 2 || op == 3 || op == 6 || op == 7 || op == 8) begin
      s = blank(); s.r_out = xo; s.a_in = 1; add(s, 0, op);
      s = blank(); s.r_out = yo; s.g_in = 1;
      s.alu_op = (op == 2) ? 3'd0 : (op == 3) ? 3'd1 : (op == 6) ? 3'd2 : (op == 7) ? 3'd3 : 3'd4;
      add(s, 0, op);
      s = blank(); s.g_out = 1; s.r_in = xo; s.done = 1; add(s, op == 6, op);
    end else if (op == 4) begin
      s = blank(); s.r_out = yo; s.addr_in = 1; add(s, 0, op);
      s = blank(); add(s, 0, op);
      s = blank(); s.memoria = 1; s.r_in = xo; s.done = 1; add(s, 0, op);
    end else if (op == 5) begin
      s = blank(); s.r_out = yo; s.addr_in = 1; add(s, 0, op);
      s = blank(); s.r_out = xo; s.dout_in = 1; add(s, 0, op);
      s = blank(); s.wren = 1; s.done = 1; add(s, 0, op);
    end else if (op == 9 && STACK) begin
      s = blank(); s.sp_dec = 1; add(s, 0, op);
      s = blank(); s.r_out = 8'h80; s.addr_in = 1; add(s, 0, op);
      s = blank(); s.r_out = xo; s.dout_in = 1; add(s, 0, op);
      s = blank(); s.wren = 1; s.done = 1; add(s, 0, op);
    end else if (op == 10 && STACK) begin
      s = blank(); s.r_out = 8'h80; s.addr_in = 1; add(s, 0, op);
      s = blank(); s.sp_inc = 1; add(s, 0, op);
      s = blank(); s.memoria = 1; s.r_in = xo; s.done = 1; add(s, 0, op);
    end else begin
      s = blank(); s.err = 1; s.done = 1; add(s, 0, op);
    end
  endfunction

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge
  initial begin
    outs_t e;
    forever begin
      @(negedge clock);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_cmp++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d got=%h expected=%h", cyc, act, e);
        end
        n_cmp++;
        if (!$onehot0(r_out)) begin
          n_fail++;
          $display("FAIL r_out_onehot cyc=%0d got=%h expected at most one bit", cyc, r_out);
        end
      end
    end
  end

  task automatic check2(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Driver: advances the reference model once per cycle, just after the rising edge
  initial begin
    logic [9:0] dir_q[$];
    bit   prev_accept = 1'b1, prev_run = 1'b0, accepting, do_rst, rst_on_ld = 1'b1;
    logic [9:0] prev_ir = '0;
    step_t st;
    outs_t e;
    dir_q = '{10'b0010_001_010, 10'b0110_101_000, 10'b0110_101_000,
              10'b1001_011_000, 10'b0000_001_010, 10'b0001_100_000,
              10'b0100_001_010};
    repeat (2) @(posedge clock);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      cyc = i;
      if (prev_accept) begin
        if (prev_run) build(prev_ir);
        else pend.delete();
      end
      do_rst = (i == 0) || ($urandom_range(0, 199) == 0);
      if (rst_on_ld && pend.size() > 0 && pend[0].op == 4 && pend[0].stp == 2) begin
        do_rst = 1'b1;
        rst_on_ld = 1'b0;
      end
      if (do_rst) begin
        resetn = 1'b0;
        pend.delete();
        sbq.push_back('0);
        run = 1'b0; ir = 10'($urandom);
        prev_accept = 1'b1; prev_run = 1'b0; prev_ir = ir;
        continue;
      end
      resetn = 1'b1;
      nz = 1'($urandom);
      if (pend.size() > 0) begin
        st = pend.pop_front();
        e = st.o;
        if (st.nz_gate && !nz) e.r_in = '0;
        accepting = e.done;
      end else begin
        e = '0;
        accepting = 1'b1;
      end
      sbq.push_back(e);
      if (accepting && dir_q.size() > 0) begin
        run = 1'b1; ir = dir_q.pop_front();
      end else begin
        run = ($urandom_range(0, 9) < 8);
        ir  = 10'($urandom);
      end
      prev_accept = accepting; prev_run = run; prev_ir = ir;
    end
    @(posedge clock); #1;
    run = 1'b0;
    repeat (3) @(negedge clock);

    // Narrow-register instance: MV r3,r0 then an illegal opcode back-to-back
    @(posedge clock); #1;
    run2 = 1'b1; ir2 = 8'b0000_11_00;
    @(posedge clock); #1;
    check2("rb2_mv_r_out", 32'(r_out2), 32'h1);
    check2("rb2_mv_r_in",  32'(r_in2),  32'h8);
    check2("rb2_mv_done",  32'(done2),  32'h1);
    ir2 = 8'b1111_0000;
    @(posedge clock); #1;
    check2("rb2_ill_err",  32'({err2, done2, busy}), 32'h6);
    check2("rb2_ill_strb", 32'({r_out2, r_in2}), 32'h0);
    run2 = 1'b0;
    @(posedge clock); #1;
    check2("rb2_idle", 32'({busy2, done2}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
